// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder memory model: request codes, FSM states
// and the latched request record.
package mem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } memresp_state_t;

    // Word index kept at full width so the range check can see every upper bit.
    typedef struct packed {
        logic        mode;
        logic [31:0] widx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memreq_t;

    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return {2'b00, off[31:2]};
    endfunction

endpackage

// File: rtl/mem_responder_resp_bram.sv
// Single-port 32-bit RAM with byte enables, read-before-write and a registered read port;
// written in the template block-RAM inference expects.
module resp_bram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Target end of the single-pulse memory request/response protocol: fixed-latency RAM access
// with one pending slot. Optional macro MEMRESP_WRITE_ECHO_EN returns old word on writes.
module mem_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        overflow,
    output logic        range_err
);
    import mem_responder_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    memresp_state_t state_q;
    logic [3:0]     cnt_q;
    logic           slot_vld_q;
    memreq_t        cur_q, cur_d, slot_q, slot_d, req_in;
    logic           response_enable_q, range_err_q, overflow_q;
    logic [31:0]    resp_data_q, resp_word, bram_rdata;
    logic           load_cur_in, load_cur_slot, load_slot, drop, commit, cur_oor;

    always_comb begin
        req_in.mode  = req_mode;
        req_in.widx  = word_index(req_addr, BASE_ADDR);
        req_in.wdata = req_wdata;
        req_in.wstrb = req_wstrb;
    end

    assign cur_oor = (cur_q.widx >> ADDR_WIDTH) != 32'd0;

    // A request landing in the response cycle with the slot empty starts straight away,
    // so it sees the same latency it would have had from IDLE.
    always_comb begin
        load_cur_in   = request_enable && ((state_q == IDLE) || (state_q == RESP && !slot_vld_q));
        load_cur_slot = (state_q == RESP) && slot_vld_q;
        load_slot     = request_enable && (state_q == BUSY) && !slot_vld_q;
        drop          = request_enable && slot_vld_q;
        commit        = (state_q == BUSY) && (cnt_q == 4'd1);
        cur_d         = cur_q;
        slot_d        = slot_q;
        if (load_cur_slot) begin
            cur_d = slot_q;
        end else if (load_cur_in) begin
            cur_d = req_in;
        end
        if (load_slot) begin
            slot_d = req_in;
        end
    end

    always_ff @(posedge clk) begin
        cur_q  <= cur_d;
        slot_q <= slot_d;
    end

    resp_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk     (clk),
        .en_i    (commit && !cur_oor),
        .we_i    ((cur_q.mode == MEMREQ_WRITE) ? cur_q.wstrb : 4'b0000),
        .addr_i  (cur_q.widx[ADDR_WIDTH-1:0]),
        .wdata_i (cur_q.wdata),
        .rdata_o (bram_rdata)
    );

`ifdef MEMRESP_WRITE_ECHO_EN
    assign resp_word = cur_oor ? 32'h0 : bram_rdata;
`else
    assign resp_word = (cur_oor || cur_q.mode == MEMREQ_WRITE) ? 32'h0 : bram_rdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= IDLE;
            cnt_q             <= 4'd0;
            slot_vld_q        <= 1'b0;
            response_enable_q <= 1'b0;
            range_err_q       <= 1'b0;
            overflow_q        <= 1'b0;
            resp_data_q       <= 32'h0;
        end else begin
            response_enable_q <= 1'b0;
            range_err_q       <= 1'b0;
            if (load_slot) begin
                slot_vld_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (request_enable) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (commit) begin
                        state_q           <= RESP;
                        response_enable_q <= 1'b1;
                        range_err_q       <= cur_oor;
                    end
                end
                RESP: begin
                    resp_data_q <= resp_word;
                    if (slot_vld_q || request_enable) begin
                        slot_vld_q <= 1'b0;
                        state_q    <= BUSY;
                        cnt_q      <= CNT_INIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM read data is only valid during RESP; afterwards the captured copy holds it.
    assign resp_data       = (state_q == RESP) ? resp_word : resp_data_q;
    assign response_enable = response_enable_q;
    assign range_err       = range_err_q;
    assign overflow        = overflow_q;

endmodule
